// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
//   - MODE_* : 3-bit operation encodings on the 'mode' port
//   - word_shifts(size, step) : ops per full word, ceil(size/step)
//   - cnt_width(ws)           : counter width, max(1, clog2(ws))
package shift_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;
   localparam logic [2:0] MODE_SAR   = 3'b111;

   function automatic int word_shifts(input int size, input int step);
      return (size + step - 1) / step;
   endfunction

   function automatic int cnt_width(input int ws);
      return (ws <= 2) ? 1 : $clog2(ws);
   endfunction

endpackage

// File: rtl/shift_word_counter.sv
// Word counter for the universal shift register.
//   clk, reset_n : clock, async active-low reset
//   inc          : one shift op was performed this cycle
//   clr          : start a new word (LOAD/CLEAR)
//   count        : shifts done in the current word
//   word_done    : one-cycle pulse after the op that completes a word
// word_done defaults low every cycle, so any cycle without a completing
// op (including enable = 0, where inc and clr are both 0) drops it.
module shift_word_counter #(
   parameter int WORD_SHIFTS = 8,
   parameter int CNT_W       = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             word_done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_SHIFTS - 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (clr) begin
            count <= '0;
         end else if (inc) begin
            if (count == LAST) begin
               count     <= '0;
               word_done <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate left/right, parallel load and
// clear on a SIZE-bit word, STEP bits per op, with a word counter.
//   clk, reset_n          : clock, async active-low reset
//   enable                : 0 holds register and counter
//   mode                  : operation select (shift_pkg::MODE_*)
//   ser_in_left/right     : bits entering on SHL (LSBs) / SHR (MSBs)
//   par_in                : parallel load data
//   out                   : registered contents
//   ser_out_left/right    : bits leaving on SHL / SHR (from out)
//   count, word_done      : shifts in current word, word-complete pulse
// Optional macro USR_ARITH_SHIFT_EN: mode 111 is an arithmetic right
// shift (counted); otherwise mode 111 behaves as HOLD.
module universal_shift_register
   import shift_pkg::*;
#(
   parameter  int SIZE  = 8,
   parameter  int STEP  = 1,
   localparam int WS    = word_shifts(SIZE, STEP),
   localparam int CNT_W = cnt_width(WS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [STEP-1:0]  ser_in_left,
   input  logic [STEP-1:0]  ser_in_right,
   input  logic [SIZE-1:0]  par_in,
   output logic [SIZE-1:0]  out,
   output logic [STEP-1:0]  ser_out_left,
   output logic [STEP-1:0]  ser_out_right,
   output logic [CNT_W-1:0] count,
   output logic             word_done
);

   if (SIZE < 2 || STEP < 1 || STEP > SIZE - 1) begin : g_bad_params
      $error("universal_shift_register: need SIZE >= 2 and 1 <= STEP <= SIZE-1");
   end

   logic [SIZE-1:0] nxt;
   logic            is_shift;
   logic            is_new_word;

   always_comb begin
      nxt         = out;
      is_shift    = 1'b0;
      is_new_word = 1'b0;
      case (mode)
         MODE_SHL: begin
            nxt      = {out[SIZE-STEP-1:0], ser_in_left};
            is_shift = 1'b1;
         end
         MODE_SHR: begin
            nxt      = {ser_in_right, out[SIZE-1:STEP]};
            is_shift = 1'b1;
         end
         MODE_ROL: begin
            nxt      = {out[SIZE-STEP-1:0], out[SIZE-1 -: STEP]};
            is_shift = 1'b1;
         end
         MODE_ROR: begin
            nxt      = {out[STEP-1:0], out[SIZE-1:STEP]};
            is_shift = 1'b1;
         end
         MODE_LOAD: begin
            nxt         = par_in;
            is_new_word = 1'b1;
         end
         MODE_CLEAR: begin
            nxt         = '0;
            is_new_word = 1'b1;
         end
`ifdef USR_ARITH_SHIFT_EN
         MODE_SAR: begin
            nxt      = {{STEP{out[SIZE-1]}}, out[SIZE-1:STEP]};
            is_shift = 1'b1;
         end
`endif
         default: begin
            nxt = out;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out <= '0;
      end else if (enable) begin
         out <= nxt;
      end
   end

   assign ser_out_left  = out[SIZE-1 -: STEP];
   assign ser_out_right = out[STEP-1:0];

   shift_word_counter #(
      .WORD_SHIFTS(WS),
      .CNT_W      (CNT_W)
   ) u_word_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .inc      (enable & is_shift),
      .clr      (enable & is_new_word),
      .count    (count),
      .word_done(word_done)
   );

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       clk_run = 1'b1;
   logic       reset_n = 1'b0;

   // DUT A: SIZE=8 STEP=1 ; DUT B: SIZE=8 STEP=2
   logic       en_a = 1'b0, en_b = 1'b0;
   logic [2:0] mode_a = 3'b000, mode_b = 3'b000;
   logic [0:0] sil_a = '0, sir_a = '0;
   logic [1:0] sil_b = '0, sir_b = '0;
   logic [7:0] par_a = '0, par_b = '0;
   logic [7:0] out_a, out_b;
   logic [0:0] sol_a, sor_a;
   logic [1:0] sol_b, sor_b;
   logic [2:0] cnt_a;
   logic [1:0] cnt_b;
   logic       wd_a, wd_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         dut;      // 0 = A, 1 = B
      string      name;
      logic [7:0] exp_out;
      int         exp_cnt;
      logic       exp_wd;
      int         chk_so;   // 0 none, 1 ser_out_left, 2 ser_out_right
      logic [1:0] exp_so;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   universal_shift_register #(.SIZE(8), .STEP(1)) u_a (
      .clk(clk), .reset_n(reset_n), .enable(en_a), .mode(mode_a),
      .ser_in_left(sil_a), .ser_in_right(sir_a), .par_in(par_a),
      .out(out_a), .ser_out_left(sol_a), .ser_out_right(sor_a),
      .count(cnt_a), .word_done(wd_a)
   );

   universal_shift_register #(.SIZE(8), .STEP(2)) u_b (
      .clk(clk), .reset_n(reset_n), .enable(en_b), .mode(mode_b),
      .ser_in_left(sil_b), .ser_in_right(sir_b), .par_in(par_b),
      .out(out_b), .ser_out_left(sol_b), .ser_out_right(sor_b),
      .count(cnt_b), .word_done(wd_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: each driven cycle has exactly one expectation, due just
   // after the following rising edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (!e.dut) begin
            chk({e.name, ".out"},   int'(out_a), int'(e.exp_out));
            chk({e.name, ".count"}, int'(cnt_a), e.exp_cnt);
            chk({e.name, ".wd"},    int'(wd_a),  int'(e.exp_wd));
            if (e.chk_so == 1) chk({e.name, ".sol"}, int'(sol_a), int'(e.exp_so));
            if (e.chk_so == 2) chk({e.name, ".sor"}, int'(sor_a), int'(e.exp_so));
         end else begin
            chk({e.name, ".out"},   int'(out_b), int'(e.exp_out));
            chk({e.name, ".count"}, int'(cnt_b), e.exp_cnt);
            chk({e.name, ".wd"},    int'(wd_b),  int'(e.exp_wd));
            if (e.chk_so == 1) chk({e.name, ".sol"}, int'(sol_b), int'(e.exp_so));
            if (e.chk_so == 2) chk({e.name, ".sor"}, int'(sor_b), int'(e.exp_so));
         end
      end
   end

   task automatic op(input bit d, input logic en, input logic [2:0] m,
                     input logic [1:0] sin, input logic [7:0] par,
                     input logic [7:0] xo, input int xc, input logic xw,
                     input int cso, input logic [1:0] xso, input string name);
      exp_t x;
      @(negedge clk);
      if (!d) begin
         en_a = en; mode_a = m; sil_a = sin[0:0]; sir_a = sin[0:0]; par_a = par;
         en_b = 1'b0;
      end else begin
         en_b = en; mode_b = m; sil_b = sin; sir_b = sin; par_b = par;
         en_a = 1'b0;
      end
      x.dut = d; x.name = name; x.exp_out = xo; x.exp_cnt = xc;
      x.exp_wd = xw; x.chk_so = cso; x.exp_so = xso;
      sb.push_back(x);
   endtask

   task automatic idle();
      @(negedge clk);
      en_a = 1'b0;
      en_b = 1'b0;
   endtask

   localparam bit A = 1'b0;
   localparam bit B = 1'b1;

   initial begin
      logic [7:0] bits;
      logic [7:0] exp_o;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // A: load / shift-left, ser_out_left before and after
      op(A, 1, 3'b101, 2'b00, 8'hA5, 8'hA5, 0, 0, 1, 2'b01, "a_load_a5");
      op(A, 1, 3'b001, 2'b01, 8'h00, 8'h4B, 1, 0, 1, 2'b00, "a_shl1");
      op(A, 1, 3'b001, 2'b00, 8'h00, 8'h96, 2, 0, 0, 2'b00, "a_shl2");
      op(A, 1, 3'b001, 2'b00, 8'h00, 8'h2C, 3, 0, 0, 2'b00, "a_shl3");
      idle();
      idle();

      // async reset mid-word with the clock stopped
      clk_run = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      chk("rst.out_a", int'(out_a), 0);
      chk("rst.cnt_a", int'(cnt_a), 0);
      chk("rst.wd_a",  int'(wd_a),  0);
      chk("rst.out_b", int'(out_b), 0);
      chk("rst.cnt_b", int'(cnt_b), 0);
      #10;
      reset_n = 1'b1;
      #2;
      clk_run = 1'b1;
      op(A, 0, 3'b101, 2'b00, 8'hFF, 8'h00, 0, 0, 0, 2'b00, "a_post_rst_dis");
      op(A, 1, 3'b000, 2'b00, 8'hFF, 8'h00, 0, 0, 0, 2'b00, "a_post_rst_hold");

      // rotates and enable hold
      op(A, 1, 3'b101, 2'b00, 8'h81, 8'h81, 0, 0, 2, 2'b01, "a_load_81");
      op(A, 1, 3'b011, 2'b00, 8'h00, 8'h03, 1, 0, 0, 2'b00, "a_rol");
      op(A, 1, 3'b101, 2'b00, 8'h81, 8'h81, 0, 0, 0, 2'b00, "a_load_81b");
      op(A, 1, 3'b100, 2'b00, 8'h00, 8'hC0, 1, 0, 2, 2'b00, "a_ror");
      for (int i = 0; i < 3; i++)
         op(A, 0, 3'b001, 2'b01, 8'hFF, 8'hC0, 1, 0, 0, 2'b00, "a_disabled");

      // full word of SHL: bits 1,0,1,1,0,0,1,0 -> 0xB2
      op(A, 1, 3'b110, 2'b00, 8'h00, 8'h00, 0, 0, 0, 2'b00, "a_clear");
      bits  = 8'b1011_0010;
      exp_o = 8'h00;
      for (int i = 0; i < 8; i++) begin
         exp_o = {exp_o[6:0], bits[7-i]};
         op(A, 1, 3'b001, {1'b0, bits[7-i]}, 8'h00, exp_o, (i + 1) % 8,
            (i == 7), 0, 2'b00, "a_word");
      end
      op(A, 1, 3'b001, 2'b00, 8'h00, 8'h64, 1, 0, 0, 2'b00, "a_shl9");
      op(A, 1, 3'b000, 2'b00, 8'h00, 8'h64, 1, 0, 0, 2'b00, "a_hold");

      // B: STEP=2 shift-right word, then load mid-word
      op(B, 1, 3'b101, 2'b00, 8'hF0, 8'hF0, 0, 0, 1, 2'b11, "b_load_f0");
      op(B, 1, 3'b010, 2'b01, 8'h00, 8'h7C, 1, 0, 2, 2'b00, "b_shr1");
      op(B, 1, 3'b010, 2'b00, 8'h00, 8'h1F, 2, 0, 0, 2'b00, "b_shr2");
      op(B, 1, 3'b010, 2'b10, 8'h00, 8'h87, 3, 0, 0, 2'b00, "b_shr3");
      op(B, 1, 3'b010, 2'b11, 8'h00, 8'hE1, 0, 1, 2, 2'b01, "b_shr4");
      op(B, 1, 3'b010, 2'b00, 8'h00, 8'h38, 1, 0, 0, 2'b00, "b_shr5");
      op(B, 1, 3'b010, 2'b00, 8'h00, 8'h0E, 2, 0, 0, 2'b00, "b_shr6");
      op(B, 1, 3'b101, 2'b00, 8'h3C, 8'h3C, 0, 0, 0, 2'b00, "b_load_mid");
      op(B, 1, 3'b000, 2'b00, 8'h00, 8'h3C, 0, 0, 0, 2'b00, "b_hold");

      // mode 111
      op(A, 1, 3'b101, 2'b00, 8'h90, 8'h90, 0, 0, 0, 2'b00, "a_load_90");
`ifdef USR_ARITH_SHIFT_EN
      op(A, 1, 3'b111, 2'b00, 8'h00, 8'hC8, 1, 0, 0, 2'b00, "a_sar");
`else
      op(A, 1, 3'b111, 2'b00, 8'h00, 8'h90, 0, 0, 0, 2'b00, "a_mode7_hold");
`endif

      idle();
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
